// File: rtl/mastermind_game_tracker.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------------------+
// | mastermind_game_tracker: guess history, turn count and win/loss decision.    |
// | Optional: MM_TRACKER_STATS_EN adds saturating games_won/games_lost counters. |
// | Revision: 1.0                                                                |
// +------------------------------------------------------------------------------+
module mastermind_game_tracker #(
  parameter int MAX_GUESSES = 8,
  parameter int PEGS        = 4,
  parameter int COLOR_W     = 3,
  parameter int CNT_W       = 4
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     new_game,
  input  logic                     result_valid,
  input  logic [PEGS*COLOR_W-1:0]  guess_in,
  input  logic [2:0]               red_in,
  input  logic [2:0]               white_in,
  input  logic [CNT_W-1:0]         rd_idx,
  output logic [PEGS*COLOR_W-1:0]  rd_guess,
  output logic [2:0]               rd_red,
  output logic [2:0]               rd_white,
  output logic                     rd_valid,
  output logic [CNT_W-1:0]         guess_count,
  output logic [1:0]               game_state,
  output logic                     accept_guess,
  output logic [2:0]               last_red,
  output logic [2:0]               last_white,
  output logic                     score_err
`ifdef MM_TRACKER_STATS_EN
  ,
  output logic [7:0]               games_won,
  output logic [7:0]               games_lost
`endif
);

  localparam int GW = PEGS * COLOR_W;

  typedef enum logic [1:0] {
    ST_PLAYING = 2'd0,
    ST_CHECK   = 2'd1,
    ST_WON     = 2'd2,
    ST_LOST    = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       guess_count_q, guess_count_d;
  logic [MAX_GUESSES-1:0] valid_q, valid_d;
  logic [GW-1:0]          hist_guess_q [MAX_GUESSES];
  logic [GW-1:0]          hist_guess_d [MAX_GUESSES];
  logic [2:0]             hist_red_q   [MAX_GUESSES];
  logic [2:0]             hist_red_d   [MAX_GUESSES];
  logic [2:0]             hist_white_q [MAX_GUESSES];
  logic [2:0]             hist_white_d [MAX_GUESSES];
  logic [2:0]             last_red_q, last_red_d;
  logic [2:0]             last_white_q, last_white_d;
  logic                   score_err_q, score_err_d;
  logic [GW-1:0]          rd_guess_q, rd_guess_d;
  logic [2:0]             rd_red_q, rd_red_d;
  logic [2:0]             rd_white_q, rd_white_d;
  logic                   rd_valid_q, rd_valid_d;
  logic [3:0]             score_sum;
  logic                   wr_en;

  always_comb begin
    state_d       = state_q;
    guess_count_d = guess_count_q;
    valid_d       = valid_q;
    hist_guess_d  = hist_guess_q;
    hist_red_d    = hist_red_q;
    hist_white_d  = hist_white_q;
    last_red_d    = last_red_q;
    last_white_d  = last_white_q;
    score_err_d   = score_err_q;
    wr_en         = 1'b0;
    score_sum     = {1'b0, red_in} + {1'b0, white_in};

    if (new_game) begin
      state_d       = ST_PLAYING;
      guess_count_d = '0;
      valid_d       = '0;
      last_red_d    = '0;
      last_white_d  = '0;
    end else begin
      case (state_q)
        ST_PLAYING: begin
          if (result_valid) begin
            wr_en         = 1'b1;
            guess_count_d = guess_count_q + 1'b1;
            last_red_d    = red_in;
            last_white_d  = white_in;
            if (score_sum > 4'(PEGS)) score_err_d = 1'b1;
            state_d       = ST_CHECK;
          end
        end
        ST_CHECK: begin
          // Win is tested first so a winning final turn is not a loss.
          if (last_red_q == 3'(PEGS))                      state_d = ST_WON;
          else if (guess_count_q == CNT_W'(MAX_GUESSES))   state_d = ST_LOST;
          else                                             state_d = ST_PLAYING;
        end
        default: ;
      endcase
    end

    // PLAYING always has guess_count < MAX_GUESSES, so the slot exists.
    for (int i = 0; i < MAX_GUESSES; i++) begin
      if (wr_en && guess_count_q == CNT_W'(i)) begin
        hist_guess_d[i] = guess_in;
        hist_red_d[i]   = red_in;
        hist_white_d[i] = white_in;
        valid_d[i]      = 1'b1;
      end
    end

    // Read from next-state contents for write-first behaviour.
    rd_guess_d = '0;
    rd_red_d   = '0;
    rd_white_d = '0;
    rd_valid_d = 1'b0;
    for (int i = 0; i < MAX_GUESSES; i++) begin
      if (rd_idx == CNT_W'(i) && valid_d[i]) begin
        rd_guess_d = hist_guess_d[i];
        rd_red_d   = hist_red_d[i];
        rd_white_d = hist_white_d[i];
        rd_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q       <= ST_PLAYING;
      guess_count_q <= '0;
      valid_q       <= '0;
      last_red_q    <= '0;
      last_white_q  <= '0;
      score_err_q   <= 1'b0;
      rd_guess_q    <= '0;
      rd_red_q      <= '0;
      rd_white_q    <= '0;
      rd_valid_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      guess_count_q <= guess_count_d;
      valid_q       <= valid_d;
      last_red_q    <= last_red_d;
      last_white_q  <= last_white_d;
      score_err_q   <= score_err_d;
      rd_guess_q    <= rd_guess_d;
      rd_red_q      <= rd_red_d;
      rd_white_q    <= rd_white_d;
      rd_valid_q    <= rd_valid_d;
    end
  end

  always_ff @(posedge clk) begin
    hist_guess_q <= hist_guess_d;
    hist_red_q   <= hist_red_d;
    hist_white_q <= hist_white_d;
  end

`ifdef MM_TRACKER_STATS_EN
  logic [7:0] games_won_q, games_won_d;
  logic [7:0] games_lost_q, games_lost_d;

  always_comb begin
    games_won_d  = games_won_q;
    games_lost_d = games_lost_q;
    if (state_q == ST_CHECK && state_d == ST_WON && games_won_q != 8'hFF)
      games_won_d = games_won_q + 8'd1;
    if (state_q == ST_CHECK && state_d == ST_LOST && games_lost_q != 8'hFF)
      games_lost_d = games_lost_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      games_won_q  <= '0;
      games_lost_q <= '0;
    end else begin
      games_won_q  <= games_won_d;
      games_lost_q <= games_lost_d;
    end
  end

  assign games_won  = games_won_q;
  assign games_lost = games_lost_q;
`else
  // Statistics build option disabled: no counters.
`endif

  assign rd_guess     = rd_guess_q;
  assign rd_red       = rd_red_q;
  assign rd_white     = rd_white_q;
  assign rd_valid     = rd_valid_q;
  assign guess_count  = guess_count_q;
  assign game_state   = (state_q == ST_WON)  ? 2'd1 :
                        (state_q == ST_LOST) ? 2'd2 : 2'd0;
  assign accept_guess = (state_q == ST_PLAYING);
  assign last_red     = last_red_q;
  assign last_white   = last_white_q;
  assign score_err    = score_err_q;

endmodule
`default_nettype wire
